// File: rtl/fifo_butterfly_reader.sv
// Radix-2 butterfly consumer: pops operand pairs from a show-ahead FIFO and emits sum/diff.
// Optional BFLY_SCALE_EN halves both results (arithmetic shift) for per-stage scaling.
module fifo_butterfly_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_SIZE   = 5,
  parameter int PAIR_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   fifo_data,
  input  logic                    fifo_empty,
  input  logic [PTR_SIZE:0]       fifo_count,
  output logic                    fifo_re,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH:0]     out_sum,
  output logic [DATA_WIDTH:0]     out_diff,
  output logic [PAIR_CNT_W-1:0]   pair_count,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OUT = 2'd2
  } state_t;

  state_t                        state;
  logic        [DATA_WIDTH-1:0]  a;
  logic        [DATA_WIDTH-1:0]  b_val;
  logic signed [DATA_WIDTH:0]    a_ext;
  logic signed [DATA_WIDTH:0]    b_ext;
  logic signed [DATA_WIDTH:0]    sum_full;
  logic signed [DATA_WIDTH:0]    diff_full;
  logic        [DATA_WIDTH:0]    sum_res;
  logic        [DATA_WIDTH:0]    diff_res;
  logic                          unused_count;

  // Occupancy is reported for status only; control relies on fifo_empty alone.
  assign unused_count = ^fifo_count;

  // b is forced to zero only on the flush path, where the FIFO is empty.
  assign b_val     = fifo_empty ? '0 : fifo_data;
  assign a_ext     = {a[DATA_WIDTH-1], a};
  assign b_ext     = {b_val[DATA_WIDTH-1], b_val};
  assign sum_full  = a_ext + b_ext;
  assign diff_full = a_ext - b_ext;

`ifdef BFLY_SCALE_EN
  assign sum_res  = sum_full >>> 1;
  assign diff_res = diff_full >>> 1;
`else
  assign sum_res  = sum_full;
  assign diff_res = diff_full;
`endif

  always_comb begin
    fifo_re = 1'b0;
    if (rst_n) begin
      case (state)
        S_A:     fifo_re = !fifo_empty;
        S_B:     fifo_re = !fifo_empty;
        S_OUT:   fifo_re = out_ready && !fifo_empty;
        default: fifo_re = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_A;
      a          <= '0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_diff   <= '0;
      pair_count <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_A: begin
          if (fifo_re) begin
            a     <= fifo_data;
            state <= S_B;
            busy  <= 1'b1;
          end
        end
        S_B: begin
          if (fifo_re || flush) begin
            out_sum   <= sum_res;
            out_diff  <= diff_res;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            pair_count <= pair_count + PAIR_CNT_W'(1);
            out_valid  <= 1'b0;
            // Back-to-back: the next operand a is popped on the acceptance edge.
            if (fifo_re) begin
              a     <= fifo_data;
              state <= S_B;
            end else begin
              state <= S_A;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= S_A;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_butterfly_reader.sv
// Scoreboard bench for fifo_butterfly_reader: a FIFO model feeds directed samples,
// expected result pairs are queued at stimulus time and checked by a separate monitor.
module tb_fifo_butterfly_reader;

  localparam int DW = 8;
`ifdef BFLY_SCALE_EN
  localparam bit SCALED = 1'b1;
`else
  localparam bit SCALED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic [5:0]    fifo_count;
  logic          fifo_re;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW:0]   out_sum;
  logic [DW:0]   out_diff;
  logic [15:0]   pair_count;
  logic          busy;

  logic [DW-1:0] mem [0:63];
  int            wr = 0;
  int            rd = 0;
  logic [17:0]   exp_q [$];
  logic [15:0]   pc_model = '0;
  int            total = 0;
  int            passed = 0;

  fifo_butterfly_reader #(.DATA_WIDTH(DW), .PTR_SIZE(5), .PAIR_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count), .fifo_re(fifo_re), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_diff(out_diff), .pair_count(pair_count), .busy(busy)
  );

  always #5 clk = ~clk;

  assign fifo_data  = mem[rd[5:0]];
  assign fifo_empty = (wr == rd);
  assign fifo_count = 6'(wr - rd);

  always @(posedge clk) begin
    if (fifo_re) rd <= rd + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [DW-1:0] x);
    mem[wr[5:0]] = x;
    wr++;
  endtask

  task automatic pushPair(input logic [DW-1:0] x, input logic [DW-1:0] y,
                          input logic [8:0] su, input logic [8:0] du,
                          input logic [8:0] ss, input logic [8:0] ds);
    applyStimulus(x);
    applyStimulus(y);
    exp_q.push_back(SCALED ? {ss, ds} : {su, du});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_sum", out_sum, 0);
    checkOutput("rst_diff", out_diff, 0);
    checkOutput("rst_pair_count", pair_count, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_re", fifo_re, 0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) checkOutput(name, 0, 1);
  endtask

  task automatic waitBStarved(input string name);
    int n = 0;
    while (!(busy && !out_valid && fifo_empty) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(busy && !out_valid && fifo_empty)) checkOutput(name, 0, 1);
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, (exp_q.size() == 0 && !busy), 1);
  endtask

  // Scoreboard monitor: compares every accepted result against the queue head.
  always @(negedge clk) begin
    logic [17:0] e;
    if (!rst_n) begin
      pc_model = '0;
    end else begin
      if (fifo_empty) checkOutput("re_while_empty", fifo_re, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_sum", out_sum, e[17:9]);
          checkOutput("out_diff", out_diff, e[8:0]);
        end
        checkOutput("pair_count", pair_count, pc_model);
        pc_model = pc_model + 16'd1;
      end
    end
  end

  initial begin
    int hits [$];
    doReset();

    pushPair(8'd100, 8'd50, 9'h096, 9'h032, 9'h04B, 9'h019);
    @(negedge clk);
    checkOutput("t1_re_a", fifo_re, 1);
    @(negedge clk);
    checkOutput("t1_re_b", fifo_re, 1);
    checkOutput("t1_busy", busy, 1);
    @(negedge clk);
    checkOutput("t1_valid", out_valid, 1);
    waitDrain("t1_drain");
    checkOutput("t1_pair_count", pair_count, 1);

    tick();
    pushPair(8'h80, 8'h7F, 9'h1FF, 9'h101, 9'h1FF, 9'h180);
    waitDrain("minmax_drain");

    doReset();
    pushPair(8'd1, 8'd2, 9'h003, 9'h1FF, 9'h001, 9'h1FF);
    pushPair(8'd10, 8'd3, 9'h00D, 9'h007, 9'h006, 9'h003);
    pushPair(8'hFB, 8'hFA, 9'h1F5, 9'h001, 9'h1FA, 9'h000);
    pushPair(8'd60, 8'hBA, 9'h1F6, 9'h082, 9'h1FB, 9'h041);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) hits.push_back(c);
    end
    checkOutput("thru_results", hits.size(), 4);
    for (int i = 0; i < hits.size(); i++) checkOutput("thru_cycle", hits[i], 2 + 2 * i);
    checkOutput("thru_pair_count", pair_count, 4);

    tick();
    out_ready = 1'b0;
    pushPair(8'd20, 8'd30, 9'h032, 9'h1F6, 9'h019, 9'h1FB);
    pushPair(8'd40, 8'd41, 9'h051, 9'h1FF, 9'h028, 9'h1FF);
    waitValid("stall_wait");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_re", fifo_re, 0);
      checkOutput("stall_valid", out_valid, 1);
      checkOutput("stall_sum", out_sum, SCALED ? 9'h019 : 9'h032);
      checkOutput("stall_diff", out_diff, SCALED ? 9'h1FB : 9'h1F6);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_re", fifo_re, 1);
    waitDrain("stall_drain");

    tick();
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("flush_sa_busy", busy, 0);
      checkOutput("flush_sa_valid", out_valid, 0);
    end
    tick();
    flush = 1'b0;
    applyStimulus(8'd7);
    waitBStarved("flush_wait_b");
    exp_q.push_back(SCALED ? {9'h003, 9'h003} : {9'h007, 9'h007});
    #1 flush = 1'b1;
    waitValid("flush_wait_valid");
    flush = 1'b0;
    waitDrain("flush_drain");

    tick();
    applyStimulus(8'd5);
    waitBStarved("rst_wait_b");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", out_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_pair_count", pair_count, 0);
    pushPair(8'd3, 8'd9, 9'h00C, 9'h1FA, 9'h006, 9'h1FD);
    #1 checkOutput("midrst_re", fifo_re, 0);
    repeat (2) @(negedge clk);
    tick();
    rst_n = 1'b1;
    waitDrain("midrst_drain");
    checkOutput("midrst_final_count", pair_count, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
